// File: rtl/camera_stream_bridge_if.sv
// Pixel-stream bus for camera_stream_bridge: sensor inputs, mode/select
// controls, framed output stream and status.
interface camera_stream_bridge_if #(
   parameter int PIXEL_WIDTH = 12,
   parameter int NUM_SOURCES = 2,
   parameter int FIFO_DEPTH  = 1024
);
   localparam int SEL_W = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;
   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

   logic [NUM_SOURCES-1:0]             piulSrcValid;
   logic [NUM_SOURCES*PIXEL_WIDTH-1:0] piulSrcData;
   logic [NUM_SOURCES-1:0]             piulSrcSof;
   logic [SEL_W-1:0]                   piulSelect;
   logic [1:0]                         piulMode;
   logic                               poul1Valid;
   logic [PIXEL_WIDTH-1:0]             poulData;
   logic                               poul1Sof;
   logic                               poul1Eol;
   logic                               piul1Ready;
   logic                               poul1Overflow;
   logic [LVL_W-1:0]                   poulLevel;
   logic [15:0]                        poulFrameCount;

   // Bridge side.
   modport master (
      input  piulSrcValid, piulSrcData, piulSrcSof, piulSelect, piulMode, piul1Ready,
      output poul1Valid, poulData, poul1Sof, poul1Eol, poul1Overflow, poulLevel,
      poulFrameCount
   );

   // Sensor/consumer/control side.
   modport slave (
      output piulSrcValid, piulSrcData, piulSrcSof, piulSelect, piulMode, piul1Ready,
      input  poul1Valid, poulData, poul1Sof, poul1Eol, poul1Overflow, poulLevel,
      poulFrameCount
   );
endinterface

// File: rtl/camera_stream_bridge.sv
// Camera stream bridge: selects one sensor source (or a generated pattern),
// frames it by pixel/line counting and buffers it in a FWFT pixel FIFO.
// Source/mode changes are only accepted while waiting for a frame start.
module camera_stream_bridge #(
   parameter int PIXEL_WIDTH  = 12,
   parameter int NUM_SOURCES  = 2,
   parameter int FIFO_DEPTH   = 1024,
   parameter int FRAME_WIDTH  = 640,
   parameter int FRAME_HEIGHT = 480
) (
   input logic                     piul1Clock,
   input logic                     piul1Reset,
   camera_stream_bridge_if.master  bus
);
   localparam int SEL_W   = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;
   localparam int ADDR_W  = $clog2(FIFO_DEPTH);
   localparam int LVL_W   = ADDR_W + 1;
   localparam int X_W     = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;
   localparam int Y_W     = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
   localparam int ENTRY_W = PIXEL_WIDTH + 2;

   localparam logic [X_W-1:0] X_MAX = X_W'(FRAME_WIDTH - 1);
   localparam logic [Y_W-1:0] Y_MAX = Y_W'(FRAME_HEIGHT - 1);

   localparam logic [1:0] ST_WAIT_SOF = 2'd0;
   localparam logic [1:0] ST_STREAM   = 2'd1;
   localparam logic [1:0] ST_DROP     = 2'd2;
   localparam logic [1:0] ST_GEN      = 2'd3;

   logic [1:0]             state_q, state_d;
   logic [SEL_W-1:0]       sel_q, sel_d;
   logic [1:0]             mode_q, mode_d;
   logic [X_W-1:0]         x_q, x_d;
   logic [Y_W-1:0]         y_q, y_d;
   logic [15:0]            frame_cnt_q, frame_cnt_d;
   logic                   overflow_q, overflow_d;
   logic [ADDR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]       count_q, count_d;
   logic [ENTRY_W-1:0]     mem_q [FIFO_DEPTH];

   logic [SEL_W-1:0]       sel_in, src_idx;
   logic                   src_valid, src_sof;
   logic [PIXEL_WIDTH-1:0] src_data, gen_data, pix_data;
   logic                   gen, pix_sof, pix_eol, pix_last;
   logic [X_W-1:0]         pix_x;
   logic [Y_W-1:0]         pix_y;
   logic                   fifo_full, fifo_rd, offer, wr_en;
   logic [ENTRY_W-1:0]     wr_entry, head;

   // Source selection and geometry of the pixel offered this cycle.
   always_comb begin
      sel_in    = (int'(bus.piulSelect) < NUM_SOURCES) ? bus.piulSelect : '0;
      src_idx   = (state_q == ST_WAIT_SOF) ? sel_in : sel_q;
      src_valid = bus.piulSrcValid[src_idx];
      src_sof   = bus.piulSrcSof[src_idx];
      src_data  = bus.piulSrcData[src_idx*PIXEL_WIDTH +: PIXEL_WIDTH];
      gen       = (state_q == ST_GEN);
      // A source SOF always restarts the frame, truncating any partial one.
      pix_sof   = gen ? ((x_q == '0) && (y_q == '0)) : src_sof;
      pix_x     = (gen || !src_sof) ? x_q : '0;
      pix_y     = (gen || !src_sof) ? y_q : '0;
      pix_eol   = (pix_x == X_MAX);
      pix_last  = pix_eol && (pix_y == Y_MAX);
      gen_data  = (mode_q == 2'b01) ?
                  PIXEL_WIDTH'(32'(pix_x) >> 3) + PIXEL_WIDTH'(pix_y) : '0;
      pix_data  = gen ? gen_data : src_data;
      wr_entry  = {pix_sof, pix_eol, pix_data};
      fifo_full = (count_q == LVL_W'(FIFO_DEPTH));
      fifo_rd   = (count_q != '0) && bus.piul1Ready;
   end

   // Framing FSM: decides whether a pixel is written, dropped or ignored.
   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      mode_d      = mode_q;
      x_d         = x_q;
      y_d         = y_q;
      frame_cnt_d = frame_cnt_q;
      overflow_d  = overflow_q;
      offer       = 1'b0;
      wr_en       = 1'b0;
      case (state_q)
         ST_WAIT_SOF: begin
            sel_d  = sel_in;
            mode_d = bus.piulMode;
            x_d    = '0;
            y_d    = '0;
            if (bus.piulMode == 2'b01 || bus.piulMode == 2'b10) begin
               state_d = ST_GEN;
            end else begin
               offer = src_valid && src_sof;
            end
         end
         ST_STREAM: offer = src_valid;
         ST_DROP:   offer = src_valid && src_sof;
         default:   offer = !fifo_full;
      endcase
      if (offer) begin
         if (fifo_full) begin
            overflow_d = 1'b1;
            state_d    = ST_DROP;
         end else begin
            wr_en = 1'b1;
            x_d   = pix_eol ? '0 : pix_x + X_W'(1);
            y_d   = pix_eol ? (pix_last ? '0 : pix_y + Y_W'(1)) : pix_y;
            if (pix_last) begin
               frame_cnt_d = frame_cnt_q + 16'd1;
               state_d     = ST_WAIT_SOF;
            end else begin
               state_d = gen ? ST_GEN : ST_STREAM;
            end
         end
      end
   end

   // FIFO pointer and occupancy bookkeeping.
   always_comb begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(wr_en);
      rd_ptr_d = rd_ptr_q + ADDR_W'(fifo_rd);
      count_d  = count_q + LVL_W'(wr_en) - LVL_W'(fifo_rd);
   end

   // Control and FIFO state registers.
   always_ff @(posedge piul1Clock or posedge piul1Reset) begin
      if (piul1Reset) begin
         state_q     <= ST_WAIT_SOF;
         sel_q       <= '0;
         mode_q      <= 2'b00;
         x_q         <= '0;
         y_q         <= '0;
         frame_cnt_q <= '0;
         overflow_q  <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         mode_q      <= mode_d;
         x_q         <= x_d;
         y_q         <= y_d;
         frame_cnt_q <= frame_cnt_d;
         overflow_q  <= overflow_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
      end
   end

   // Pixel storage; contents are meaningless once count is cleared by reset.
   always_ff @(posedge piul1Clock) begin
      if (wr_en) mem_q[wr_ptr_q] <= wr_entry;
   end

   // FWFT output: head entry shown while occupied, zeros otherwise.
   always_comb begin
      head               = mem_q[rd_ptr_q];
      bus.poul1Valid     = (count_q != '0);
      bus.poul1Sof       = bus.poul1Valid && head[ENTRY_W-1];
      bus.poul1Eol       = bus.poul1Valid && head[ENTRY_W-2];
      bus.poulData       = bus.poul1Valid ? head[PIXEL_WIDTH-1:0] : '0;
      bus.poul1Overflow  = overflow_q;
      bus.poulLevel      = count_q;
      bus.poulFrameCount = frame_cnt_q;
   end
endmodule

// File: tb/tb_camera_stream_bridge.sv
// Randomised and directed bench for camera_stream_bridge with a
// pixel-index reference model and an expected-output scoreboard.
module tb_camera_stream_bridge;
   localparam int PW    = 12;
   localparam int NS    = 2;
   localparam int DEPTH = 4;
   localparam int W     = 8;
   localparam int H     = 2;
   localparam int NPIX  = W * H;

   typedef struct packed {
      logic          sof;
      logic          eol;
      logic [PW-1:0] data;
   } px_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   out_cnt = 0;

   camera_stream_bridge_if #(.PIXEL_WIDTH(PW), .NUM_SOURCES(NS), .FIFO_DEPTH(DEPTH)) bif ();

   camera_stream_bridge #(
      .PIXEL_WIDTH(PW), .NUM_SOURCES(NS), .FIFO_DEPTH(DEPTH),
      .FRAME_WIDTH(W), .FRAME_HEIGHT(H)
   ) dut (
      .piul1Clock(clk),
      .piul1Reset(rst),
      .bus(bif)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // States: 0 waiting for frame start, 1 streaming, 2 discarding, 3 generating.
   px_t         exp_q[$];
   int          m_state, m_sel, m_mode, m_n, m_level;
   logic [15:0] m_fc;
   logic        m_ovf, m_full, m_push;

   task automatic model_write(input logic [PW-1:0] d, input int next_state);
      px_t p;
      p.sof  = (m_n == 0);
      p.eol  = ((m_n % W) == W - 1);
      p.data = d;
      exp_q.push_back(p);
      m_push = 1'b1;
      if (m_n == NPIX - 1) begin
         m_fc++;
         m_n     = 0;
         m_state = 0;
      end else begin
         m_n++;
         m_state = next_state;
      end
   endtask

   task automatic model_src(input logic [PW-1:0] d);
      if (m_full) begin
         m_ovf   = 1'b1;
         m_state = 2;
      end else begin
         model_write(d, 1);
      end
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_q.delete();
         m_state = 0; m_sel = 0; m_mode = 0; m_n = 0; m_level = 0;
         m_fc = '0; m_ovf = 1'b0;
      end else begin
         int            sel_in, cur, md;
         logic          rd, v, s;
         logic [PW-1:0] d;
         m_full = (m_level == DEPTH);
         rd     = (m_level > 0) && bif.piul1Ready;
         m_push = 1'b0;
         md     = int'(bif.piulMode);
         sel_in = (int'(bif.piulSelect) < NS) ? int'(bif.piulSelect) : 0;
         cur    = (m_state == 0) ? sel_in : m_sel;
         v      = bif.piulSrcValid[cur];
         s      = bif.piulSrcSof[cur];
         d      = bif.piulSrcData[cur*PW +: PW];
         case (m_state)
            0: begin
               m_sel  = sel_in;
               m_mode = md;
               if (md == 1 || md == 2) begin
                  m_state = 3;
                  m_n     = 0;
               end else if (v && s) begin
                  m_n = 0;
                  model_src(d);
               end
            end
            1: if (v) begin
               if (s) m_n = 0;
               model_src(d);
            end
            2: if (v && s) begin
               m_n = 0;
               model_src(d);
            end
            default: if (!m_full) begin
               model_write((m_mode == 1) ? PW'(((m_n % W) >> 3) + (m_n / W)) : '0, 3);
            end
         endcase
         m_level = m_level + int'(m_push) - int'(rd);
      end
   end

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (!rst) begin
         check("valid", 32'(bif.poul1Valid), 32'(m_level > 0));
         check("level", 32'(bif.poulLevel), 32'(m_level));
         if (bif.poul1Valid && bif.piul1Ready) begin
            px_t e;
            out_cnt++;
            if (exp_q.size() == 0) begin
               check("unexpected_output", 32'(bif.poulData), 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               check("data", 32'(bif.poulData), 32'(e.data));
               check("sof_eol", {30'd0, bif.poul1Sof, bif.poul1Eol}, {30'd0, e.sof, e.eol});
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive(input logic [1:0] v, input logic [1:0] s,
                        input logic [PW-1:0] d0, input logic [PW-1:0] d1);
      bif.piulSrcValid = v;
      bif.piulSrcSof   = s;
      bif.piulSrcData  = {d1, d0};
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(2'b00, 2'b00, '0, '0);
   endtask

   task automatic check_status(input string name);
      check({name, "_fc"}, 32'(bif.poulFrameCount), 32'(m_fc));
      check({name, "_ovf"}, 32'(bif.poul1Overflow), 32'(m_ovf));
   endtask

   initial begin
      logic [15:0] fc_before;
      int          cnt_before;
      bif.piulSrcValid = '0;
      bif.piulSrcSof   = '0;
      bif.piulSrcData  = '0;
      bif.piulSelect   = '0;
      bif.piulMode     = 2'b00;
      bif.piul1Ready   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 32'(bif.poul1Valid), 32'd0);
      check("rst_data", 32'(bif.poulData), 32'd0);
      check("rst_marks", {30'd0, bif.poul1Sof, bif.poul1Eol}, 32'd0);
      check("rst_ovf", 32'(bif.poul1Overflow), 32'd0);
      check("rst_level", 32'(bif.poulLevel), 32'd0);
      check("rst_fc", 32'(bif.poulFrameCount), 32'd0);
      rst = 1'b0;

      // Plain frame from source 0, source 1 chattering underneath.
      bif.piul1Ready = 1'b1;
      for (int i = 0; i < NPIX; i++)
         drive({1'($urandom), 1'b1}, {1'($urandom), 1'(i == 0)}, PW'(i), PW'($urandom));
      idle(4);
      check("t1_fc", 32'(bif.poulFrameCount), 32'd1);
      check_status("t1");

      // Select switched mid-frame: takes effect at the next source-1 SOF.
      for (int i = 0; i < NPIX; i++) begin
         if (i == 4) bif.piulSelect = 1'b1;
         drive(2'b11, {1'b0, 1'(i == 0)}, PW'(12'h100 + i), PW'(12'h800 + i));
      end
      for (int i = 0; i < 3; i++) drive(2'b10, 2'b00, '0, PW'(12'h900 + i));
      for (int i = 0; i < NPIX; i++)
         drive(2'b11, {1'(i == 0), 1'b1}, PW'(12'h700), PW'(12'h200 + i));
      idle(4);
      check("t2_fc", 32'(bif.poulFrameCount), 32'd3);
      check_status("t2");

      // Overflow with the consumer stalled.
      bif.piulSelect = 1'b0;
      idle(2);
      bif.piul1Ready = 1'b0;
      for (int i = 0; i < 6; i++) drive(2'b01, {1'b0, 1'(i == 0)}, PW'(12'h300 + i), '0);
      check("t3_level", 32'(bif.poulLevel), 32'd4);
      check("t3_ovf", 32'(bif.poul1Overflow), 32'd1);
      for (int i = 6; i < NPIX; i++) drive(2'b01, 2'b00, PW'(12'h300 + i), '0);
      bif.piul1Ready = 1'b1;
      idle(6);
      for (int i = 0; i < NPIX; i++) drive(2'b01, {1'b0, 1'(i == 0)}, PW'(12'h400 + i), '0);
      idle(4);
      check("t3_fc", 32'(bif.poulFrameCount), 32'd4);
      check_status("t3");

      // Generated frames: test pattern, then black.
      bif.piulMode = 2'b01;
      idle(1);
      bif.piulMode = 2'b00;
      idle(22);
      check("t4_fc", 32'(bif.poulFrameCount), 32'd5);
      bif.piulMode = 2'b10;
      idle(1);
      bif.piulMode = 2'b00;
      idle(22);
      check("t4b_fc", 32'(bif.poulFrameCount), 32'd6);

      // Early SOF at pixel 5 truncates the frame without counting it.
      fc_before = m_fc;
      for (int i = 0; i < 5; i++) drive(2'b01, {1'b0, 1'(i == 0)}, PW'(12'h500 + i), '0);
      for (int i = 0; i < 10; i++) drive(2'b01, {1'b0, 1'(i == 0)}, PW'(12'h600 + i), '0);
      idle(3);
      check("t5_fc_hold", 32'(bif.poulFrameCount), 32'(fc_before));
      for (int i = 10; i < NPIX; i++) drive(2'b01, 2'b00, PW'(12'h600 + i), '0);
      idle(3);
      check("t5_fc_inc", 32'(bif.poulFrameCount), 32'(fc_before + 16'd1));

      // Randomised traffic with backpressure and occasional mode/select changes.
      for (int c = 0; c < 1500; c++) begin
         int r;
         r = $urandom_range(0, 99);
         bif.piulMode   = (r < 3) ? 2'b01 : (r < 6) ? 2'b10 : (r < 10) ? 2'b11 : 2'b00;
         bif.piulSelect = 1'($urandom_range(0, 99) < 20);
         bif.piul1Ready = ($urandom_range(0, 99) < 70);
         drive({1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 60)},
               {1'($urandom_range(0, 99) < 6), 1'($urandom_range(0, 99) < 6)},
               PW'($urandom), PW'($urandom));
      end
      bif.piulMode   = 2'b00;
      bif.piul1Ready = 1'b1;
      idle(60);
      check_status("t6");

      // Reset with three pixels buffered.
      bif.piulSelect = 1'b0;
      bif.piul1Ready = 1'b0;
      for (int i = 0; i < 3; i++)
         drive(2'b11, {1'(i == 0), 1'(i == 0)}, PW'(12'hA00 + i), PW'(12'hA00 + i));
      check("t7_level_pre", 32'(bif.poulLevel), 32'd3);
      #2;
      rst = 1'b1;
      #1;
      check("t7_rst_valid", 32'(bif.poul1Valid), 32'd0);
      check("t7_rst_level", 32'(bif.poulLevel), 32'd0);
      check("t7_rst_data", 32'(bif.poulData), 32'd0);
      check("t7_rst_fc", 32'(bif.poulFrameCount), 32'd0);
      check("t7_rst_ovf", 32'(bif.poul1Overflow), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      bif.piul1Ready = 1'b1;
      cnt_before = out_cnt;
      for (int i = 0; i < 10; i++) drive(2'b01, 2'b00, PW'(12'hB00 + i), '0);
      idle(3);
      check("t7_no_output", 32'(out_cnt - cnt_before), 32'd0);
      for (int i = 0; i < NPIX; i++) drive(2'b01, {1'b0, 1'(i == 0)}, PW'(12'hC00 + i), '0);
      idle(4);
      check("t7_fc", 32'(bif.poulFrameCount), 32'd1);

      // Bounded drain of anything still expected.
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) idle(1);
      check("drain_empty", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/camera_stream_bridge.md
Name: camera_stream_bridge

Overview:
Parametrised pixel-stream bridge between N image-sensor capture channels and a single display-side consumer, all in one clock domain. It selects one source, frames it by pixel/line counting, buffers it in an elastic FIFO and emits a framed stream with SOF/EOL markers. It can also substitute a built-in test pattern or black frames. All source and mode switching takes effect only at frame boundaries.

Parameters:
PIXEL_WIDTH, 12, bits per pixel.
NUM_SOURCES, 2, number of sensor input channels (>=1).
FIFO_DEPTH, 1024, entries of the pixel FIFO; power of two, >=4.
FRAME_WIDTH, 640, pixels per line.
FRAME_HEIGHT, 480, lines per frame.

Ports:
piul1Clock  in  1  system clock.
piul1Reset  in  1  reset, asynchronous, active-high.
piulSrcValid  in  NUM_SOURCES  per-source pixel strobe; sources cannot be stalled.
piulSrcData  in  NUM_SOURCES*PIXEL_WIDTH  per-source pixel; source i occupies bits [i*PIXEL_WIDTH +: PIXEL_WIDTH].
piulSrcSof  in  NUM_SOURCES  marks the first pixel of a frame; qualified by valid.
piulSelect  in  max(1,$clog2(NUM_SOURCES))  requested source index.
piulMode  in  2  00 = pass, 01 = test pattern, 10 = black, 11 = pass.
poul1Valid  out  1  output pixel valid.
poulData  out  PIXEL_WIDTH  output pixel.
poul1Sof  out  1  first pixel of the output frame.
poul1Eol  out  1  last pixel of each output line.
piul1Ready  in  1  consumer accepts the pixel when valid && ready.
poul1Overflow  out  1  sticky; set on any dropped pixel; cleared only by reset.
poulLevel  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
poulFrameCount  out  16  completed frames written to the FIFO; wraps 0xFFFF -> 0.

Behaviour:
- Reset (async assert, sync release): all outputs 0; FIFO empty; FSM in WAIT_SOF; latched select = 0; latched mode = 00.
- FSM states: WAIT_SOF, STREAM, DROP, GEN.
- WAIT_SOF: latch piulSelect and piulMode every cycle. Out-of-range select (>= NUM_SOURCES) latches as 0.
  - Pass mode: go to STREAM on valid && SOF from the latched source; that pixel is written with sof = 1.
  - Mode 01/10: go to GEN immediately.
- STREAM: each valid pixel of the latched source is written as {sof, eol, data}.
  - Counters x (0..FRAME_WIDTH-1) and y (0..FRAME_HEIGHT-1); eol = (x == FRAME_WIDTH-1).
  - The last pixel (x,y at maximum) increments poulFrameCount; next state WAIT_SOF.
  - Early SOF (mid-frame): the current frame is truncated without padding. The SOF pixel starts a new frame (x = y = 0, sof = 1); poulFrameCount is not incremented.
  - Non-selected sources are ignored at all times.
- Overflow: valid pixel with FIFO full -> pixel dropped, poul1Overflow <= 1, state DROP.
- DROP: discard all input until the next SOF of the latched source. That SOF pixel is written (if space exists) and the state returns to STREAM. Select and mode are not re-latched in DROP.
- GEN: writes one pixel per cycle whenever the FIFO is not full, using the same x/y counters and markers.
  - Test-pattern data = ((x >> 3) + y) truncated to PIXEL_WIDTH.
  - Black data = 0.
  - At frame end: increment frame count, go to WAIT_SOF.
  - Source inputs are ignored in GEN; no overflow is possible.
- FIFO is first-word-fall-through, registered.
  - Entry written in cycle N is visible on the outputs in cycle N+1 when the FIFO was empty.
  - Simultaneous read and write when full is not allowed; a write at full is always a drop.
  - Read and write in the same cycle at any non-full level: level unchanged.
  - poulLevel reflects the post-edge occupancy.
- Outputs hold stable while poul1Valid && !piul1Ready.
- Mid-operation reset: FIFO contents are discarded; the partial frame is never emitted.

Test Plan:
- FRAME_WIDTH=8, FRAME_HEIGHT=2, pass, select 0, 16 valid pixels 0..15 with SOF on the first, ready=1 -> 16 outputs; data 0..15 in order; sof only on data 0; eol on data 7 and 15; poulFrameCount=1; first output one cycle after the first write.
- Same setup, select toggled to 1 mid-frame -> frame 1 fully from source 0; frame 2 taken from source 1 starting at its next SOF; source-1 pixels before that SOF never appear.
- FIFO_DEPTH=4, ready=0, 6 valid pixels -> level=4; poul1Overflow=1; pixels 5–6 and the rest of the frame dropped; after ready=1 and a new SOF, streaming resumes with sof=1.
- Mode 01, 8x2 frame, ready=1 -> data 0,0,0,0,0,0,0,0 then 1,1,1,1,1,1,1,1; eol on the 8th and 16th pixels; frame count +1. Mode 10 -> all 16 pixels are 0.
- Early SOF at pixel 5 of an 8x2 frame -> sof re-asserted on that pixel; no eol before it; poulFrameCount unchanged until the next complete frame.
- Reset asserted mid-frame with FIFO level 3 -> all outputs 0 and level 0 in the same cycle; after release, nothing is output until a new SOF.
